// File: rtl/risc_controller.sv
// -----------------------------------------------------------------------------
// risc_controller
//   Instruction-sequencing controller for the VeriRISC CPU. An 8-phase counter
//   steps once per clk. A combinational decode of the registered phase and the
//   live opcode/zero inputs drives the memory strobes and the datapath controls.
//
//   Optional feature macro: CTRL_HALT_LATCH_EN
//     defined   : HLT sets a sticky halted flag. Phase then freezes at OP_FETCH
//                 with only halt asserted, until rst_n clears the flag.
//     undefined : halt is a one-cycle pulse in OP_ADDR and the phase keeps
//                 cycling. An external clock enable stops the CPU.
//
// Ports
//   clk     in   1        rising-edge clock
//   rst_n   in   1        asynchronous active-low reset
//   opcode  in   OPWIDTH  current IR opcode
//   zero    in   1        accumulator == 0
//   sel     out  1        1 = address mux selects PC, 0 = IR operand
//   rd      out  1        memory read strobe
//   wr      out  1        memory write strobe
//   ld_ir   out  1        load instruction register
//   inc_pc  out  1        increment program counter
//   ld_pc   out  1        load PC from IR operand
//   ld_ac   out  1        load accumulator from ALU
//   data_e  out  1        accumulator bus driver enable
//   halt    out  1        processor halted
//
// Phase table
//   phase      | meaning
//   INST_ADDR  | PC onto address bus
//   INST_FETCH | read instruction
//   INST_LOAD  | load IR
//   IDLE       | hold IR load, opcode settles
//   OP_ADDR    | increment PC, flag HLT
//   OP_FETCH   | read operand for ALU ops
//   ALU_OP     | skip / jump / drive bus for store
//   STORE      | load AC, jump, write memory
// -----------------------------------------------------------------------------
module risc_controller #(
  parameter int OPWIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OPWIDTH-1:0] opcode,
  input  logic               zero,
  output logic               sel,
  output logic               rd,
  output logic               wr,
  output logic               ld_ir,
  output logic               inc_pc,
  output logic               ld_pc,
  output logic               ld_ac,
  output logic               data_e,
  output logic               halt
);

  if (OPWIDTH != 3) begin : g_bad_opwidth
    $error("risc_controller: OPWIDTH must be 3");
  end

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  localparam logic [OPWIDTH-1:0] OP_HLT = OPWIDTH'(0);
  localparam logic [OPWIDTH-1:0] OP_SKZ = OPWIDTH'(1);
  localparam logic [OPWIDTH-1:0] OP_ADD = OPWIDTH'(2);
  localparam logic [OPWIDTH-1:0] OP_AND = OPWIDTH'(3);
  localparam logic [OPWIDTH-1:0] OP_XOR = OPWIDTH'(4);
  localparam logic [OPWIDTH-1:0] OP_LDA = OPWIDTH'(5);
  localparam logic [OPWIDTH-1:0] OP_STO = OPWIDTH'(6);
  localparam logic [OPWIDTH-1:0] OP_JMP = OPWIDTH'(7);

  phase_e phase_q, phase_d;

  logic is_hlt, is_skz, is_sto, is_jmp, is_alu;

  assign is_hlt = (opcode == OP_HLT);
  assign is_skz = (opcode == OP_SKZ);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

`ifdef CTRL_HALT_LATCH_EN
  logic halted_q, halted_d;

  always_comb begin
    halted_d = halted_q;
    if (phase_q == OP_ADDR && is_hlt) halted_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end

  // Once halted, the counter parks at OP_FETCH (the phase after OP_ADDR).
  always_comb begin
    phase_d = phase_e'(phase_q + 3'd1);
    if (halted_q) phase_d = OP_FETCH;
  end
`else
  always_comb begin
    phase_d = phase_e'(phase_q + 3'd1);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= INST_ADDR;
    else        phase_q <= phase_d;
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    case (phase_q)
      INST_ADDR: begin
        sel = 1'b1;
      end
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = is_hlt;
      end
      OP_FETCH: begin
        rd = is_alu;
      end
      ALU_OP: begin
        rd     = is_alu;
        inc_pc = is_skz && zero;
        ld_pc  = is_jmp;
        data_e = is_sto;
      end
      STORE: begin
        rd     = is_alu;
        ld_ac  = is_alu;
        ld_pc  = is_jmp;
        wr     = is_sto;
        data_e = is_sto;
      end
      default: begin
      end
    endcase
`ifdef CTRL_HALT_LATCH_EN
    if (halted_q) begin
      sel    = 1'b0;
      rd     = 1'b0;
      wr     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      data_e = 1'b0;
      halt   = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_risc_controller.sv
// -----------------------------------------------------------------------------
// tb_risc_controller
//   Directed bench for risc_controller. Output vectors are packed as
//   {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt}.
// -----------------------------------------------------------------------------
module tb_risc_controller;

  logic       clk;
  logic       rst_n;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt;

  logic [8:0] outs;
  logic [8:0] exp_tbl [8];
  int         n_total;
  int         n_pass;

  assign outs = {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt};

  risc_controller #(.OPWIDTH(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .wr     (wr),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .data_e (data_e),
    .halt   (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
  endtask

  task automatic chk_phase(input string tag, input logic [2:0] expp);
    chk({tag, "_phase"}, {6'd0, 3'(dut.phase_q)}, {6'd0, expp});
  endtask

  // Fetch phases are the same for every opcode.
  task automatic set_fetch_rows();
    exp_tbl[0] = 9'b100000000;
    exp_tbl[1] = 9'b110000000;
    exp_tbl[2] = 9'b110100000;
    exp_tbl[3] = 9'b110100000;
  endtask

  // Starts at a negedge with the DUT in phase 0; ends at the negedge after nph cycles.
  task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                           input int nph);
    opcode = op;
    zero   = z;
    for (int p = 0; p < nph; p++) begin
      chk($sformatf("%s_p%0d", tag, p), outs, exp_tbl[p]);
      chk_phase($sformatf("%s_p%0d", tag, p), 3'(p));
      chk($sformatf("%s_p%0d_rdwr", tag, p), {8'd0, rd & wr}, 9'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    opcode  = 3'd5;
    zero    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outs", outs, 9'b100000000);
    chk_phase("reset", 3'd0);
    rst_n = 1'b1;

    // LDA
    set_fetch_rows();
    exp_tbl[4] = 9'b000010000;
    exp_tbl[5] = 9'b010000000;
    exp_tbl[6] = 9'b010000000;
    exp_tbl[7] = 9'b010000100;
    run_instr("lda", 3'd5, 1'b0, 8);

    // STO
    exp_tbl[4] = 9'b000010000;
    exp_tbl[5] = 9'b000000000;
    exp_tbl[6] = 9'b000000010;
    exp_tbl[7] = 9'b001000010;
    run_instr("sto", 3'd6, 1'b0, 8);

    // SKZ with zero=1, then zero=0
    exp_tbl[4] = 9'b000010000;
    exp_tbl[5] = 9'b000000000;
    exp_tbl[6] = 9'b000010000;
    exp_tbl[7] = 9'b000000000;
    run_instr("skz_z1", 3'd1, 1'b1, 8);
    exp_tbl[6] = 9'b000000000;
    run_instr("skz_z0", 3'd1, 1'b0, 8);

    // JMP
    exp_tbl[4] = 9'b000010000;
    exp_tbl[5] = 9'b000000000;
    exp_tbl[6] = 9'b000001000;
    exp_tbl[7] = 9'b000001000;
    run_instr("jmp", 3'd7, 1'b0, 8);

    // ADD with zero=1 must not skip
    exp_tbl[4] = 9'b000010000;
    exp_tbl[5] = 9'b010000000;
    exp_tbl[6] = 9'b010000000;
    exp_tbl[7] = 9'b010000100;
    run_instr("add", 3'd2, 1'b1, 8);

    // Asynchronous reset in the middle of STORE for STO
    exp_tbl[4] = 9'b000010000;
    exp_tbl[5] = 9'b000000000;
    exp_tbl[6] = 9'b000000010;
    exp_tbl[7] = 9'b001000010;
    run_instr("sto_abort", 3'd6, 1'b0, 7);
    chk("sto_abort_store_wr", outs, 9'b001000010);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_outs", outs, 9'b100000000);
    chk_phase("abort", 3'd0);
    @(negedge clk);
    chk("abort_held", outs, 9'b100000000);
    rst_n = 1'b1;

    // Restart from phase 0 after release
    exp_tbl[4] = 9'b000010000;
    exp_tbl[5] = 9'b010000000;
    exp_tbl[6] = 9'b010000000;
    exp_tbl[7] = 9'b010000100;
    run_instr("restart", 3'd4, 1'b0, 8);

    // HLT
    exp_tbl[4] = 9'b000010001;
`ifdef CTRL_HALT_LATCH_EN
    run_instr("hlt", 3'd0, 1'b0, 5);
    for (int c = 0; c < 22; c++) begin
      opcode = 3'(c);
      zero   = c[0];
      chk($sformatf("halted_c%0d", c), outs, 9'b000000001);
      chk_phase($sformatf("halted_c%0d", c), 3'd5);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("halt_clear_outs", outs, 9'b100000000);
    chk_phase("halt_clear", 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
`else
    exp_tbl[5] = 9'b000000000;
    exp_tbl[6] = 9'b000000000;
    exp_tbl[7] = 9'b000000000;
    run_instr("hlt", 3'd0, 1'b0, 8);
`endif

    // Back to normal sequencing (wrap after HLT, or after clearing the latch)
    exp_tbl[4] = 9'b000010000;
    exp_tbl[5] = 9'b010000000;
    exp_tbl[6] = 9'b010000000;
    exp_tbl[7] = 9'b010000100;
    run_instr("post_hlt", 3'd3, 1'b0, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
